// File: rtl/grf_hazard_scheduler_pkg.sv
// Shared types and constants for the GRF hazard scheduler.
// Slot layout, forward-select encodings and MDU latency defaults.
package grf_hazard_scheduler_pkg;

  localparam int REG_W = 5;
  localparam int T_W   = 2;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_M   = 2'd1;
  localparam logic [1:0] FWD_E   = 2'd2;

  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic             wr;
    logic [REG_W-1:0] a3;
    logic [T_W-1:0]   tnew;
  } slot_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] fwd;
  } src_res_t;

  localparam slot_t SLOT_EMPTY = '0;

  function automatic logic [T_W-1:0] sat_dec(
    input logic [T_W-1:0] x
  );
    return (x == '0) ? x : x - T_W'(1);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy window counter.
// Loads the unit latency on a start, then counts down to idle.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic div,
  output logic busy
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= div ? CNT_W'(DIV_CYCLES)
                   : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/grf_hazard_scheduler.sv
// D-stage issue scheduler: tracks E/M/W register writes and the
// MDU busy window, producing stall and operand forward selects.
module grf_hazard_scheduler
  import grf_hazard_scheduler_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_regwrite,
  input  logic [4:0] d_a3,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic       issue,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic       md_busy
);

  slot_t    e_q, m_q, w_q;
  src_res_t rs_res, rt_res;
  logic     md_stall;

  // Only the youngest matching slot counts; W forwards via the GRF.
  function automatic src_res_t src_check(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input slot_t      e,
    input slot_t      m,
    input slot_t      w
  );
    src_res_t   res;
    slot_t      s;
    logic       hit;
    logic [1:0] sel;
    res = '0;
    s   = SLOT_EMPTY;
    hit = 1'b0;
    sel = FWD_GRF;
    if (r != '0 && tuse != TUSE_NONE) begin
      if (e.wr && e.a3 == r) begin
        hit = 1'b1;
        s   = e;
        sel = FWD_E;
      end else if (m.wr && m.a3 == r) begin
        hit = 1'b1;
        s   = m;
        sel = FWD_M;
      end else if (w.wr && w.a3 == r) begin
        hit = 1'b1;
        s   = w;
        sel = FWD_GRF;
      end
    end
    if (hit) begin
      res.stall = (s.tnew > tuse);
      if (s.tnew == '0) res.fwd = sel;
    end
    return res;
  endfunction

  always_comb begin
    rs_res = src_check(d_rs, d_tuse_rs, e_q, m_q, w_q);
    rt_res = src_check(d_rt, d_tuse_rt, e_q, m_q, w_q);
  end

  assign md_stall = d_md_use & md_busy;
  assign stall    = d_valid
                  & (rs_res.stall | rt_res.stall | md_stall);
  assign issue    = d_valid & ~stall;
  assign fwd_rs_d = stall ? FWD_GRF : rs_res.fwd;
  assign fwd_rt_d = stall ? FWD_GRF : rt_res.fwd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= SLOT_EMPTY;
      m_q <= SLOT_EMPTY;
      w_q <= SLOT_EMPTY;
    end else begin
      w_q <= '{wr: m_q.wr, a3: m_q.a3, tnew: '0};
      m_q <= '{wr: e_q.wr, a3: e_q.a3,
               tnew: sat_dec(e_q.tnew)};
      if (issue) begin
        e_q <= '{wr: d_regwrite & (d_a3 != '0),
                 a3: d_a3, tnew: d_tnew};
      end else begin
        e_q <= SLOT_EMPTY;
      end
    end
  end

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_cnt (
    .clk  (clk),
    .reset(reset),
    .load (issue & d_md_start),
    .div  (d_md_div),
    .busy (md_busy)
  );

endmodule

// File: tb/tb_grf_hazard_scheduler.sv
// Self-checking bench for grf_hazard_scheduler: directed scenarios
// plus randomized traffic against an age-based producer model.
module tb_grf_hazard_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_regwrite, d_md_start, d_md_div, d_md_use;
  logic       stall, issue, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d;

  always #5 clk = ~clk;

  grf_hazard_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .d_valid   (d_valid),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_regwrite(d_regwrite),
    .d_a3      (d_a3),
    .d_tnew    (d_tnew),
    .d_md_start(d_md_start),
    .d_md_div  (d_md_div),
    .d_md_use  (d_md_use),
    .stall     (stall),
    .issue     (issue),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .md_busy   (md_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: what was issued 1, 2, 3 cycles ago, plus MDU busy horizon.
  typedef struct {
    bit wr;
    int a3;
    int tnew;
  } prod_t;

  prod_t hist [1:3];
  int    cyc;
  int    busy_end;
  bit    m_stall, m_issue, m_busy;
  int    m_fwd_rs, m_fwd_rt;

  function automatic void src(input int r, input int tuse,
                              output bit st, output int f);
    int rem;
    st = 0;
    f  = 0;
    if (r == 0 || tuse == 3) return;
    for (int k = 1; k <= 3; k++) begin
      if (hist[k].wr && hist[k].a3 == r) begin
        rem = (k == 3) ? 0 : hist[k].tnew - (k - 1);
        if (rem < 0) rem = 0;
        st = (rem > tuse);
        if (rem == 0 && k < 3) f = 3 - k;
        return;
      end
    end
  endfunction

  function automatic void model_eval();
    bit st_rs, st_rt;
    int f_rs, f_rt;
    m_busy = (cyc <= busy_end);
    src(int'(d_rs), int'(d_tuse_rs), st_rs, f_rs);
    src(int'(d_rt), int'(d_tuse_rt), st_rt, f_rt);
    m_stall  = d_valid && (st_rs || st_rt || (d_md_use && m_busy));
    m_issue  = d_valid && !m_stall;
    m_fwd_rs = m_stall ? 0 : f_rs;
    m_fwd_rt = m_stall ? 0 : f_rt;
  endfunction

  function automatic void model_clock();
    hist[3] = hist[2];
    hist[2] = hist[1];
    if (m_issue) begin
      hist[1] = '{wr: d_regwrite, a3: int'(d_a3), tnew: int'(d_tnew)};
      if (d_md_start) busy_end = cyc + (d_md_div ? 10 : 5);
    end else begin
      hist[1] = '{wr: 0, a3: 0, tnew: 0};
    end
    cyc++;
  endfunction

  function automatic void model_reset();
    for (int k = 1; k <= 3; k++) hist[k] = '{wr: 0, a3: 0, tnew: 0};
    busy_end = cyc - 1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic drv(input bit v, input int rs, input int trs,
                     input int rt, input int trt, input bit rw,
                     input int a3, input int tn, input bit ms,
                     input bit md, input bit mu);
    d_valid    = v;
    d_rs       = 5'(rs);
    d_tuse_rs  = 2'(trs);
    d_rt       = 5'(rt);
    d_tuse_rt  = 2'(trt);
    d_regwrite = rw;
    d_a3       = 5'(a3);
    d_tnew     = 2'(tn);
    d_md_start = ms;
    d_md_div   = md;
    d_md_use   = mu;
  endtask

  // One cycle: compare at negedge, advance model at posedge.
  task automatic tick();
    @(negedge clk);
    model_eval();
    chk("stall", int'(stall), int'(m_stall));
    chk("issue", int'(issue), int'(m_issue));
    chk("fwd_rs", int'(fwd_rs_d), m_fwd_rs);
    chk("fwd_rt", int'(fwd_rt_d), m_fwd_rt);
    chk("md_busy", int'(md_busy), int'(m_busy));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    reset = 1'b1;
    drv(1, 8, 0, 9, 0, 1, 8, 2, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", int'(stall), 0);
    chk("rst_issue", int'(issue), 1);
    chk("rst_fwd_rs", int'(fwd_rs_d), 0);
    chk("rst_fwd_rt", int'(fwd_rt_d), 0);
    chk("rst_busy", int'(md_busy), 0);
    drv(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // load-use
    drv(1, 0, 3, 0, 3, 1, 8, 2, 0, 0, 0);
    tick();
    drv(1, 8, 0, 0, 3, 1, 10, 1, 0, 0, 0);
    #1 chk("lu_stall1", int'(stall), 1);
    model_eval();
    chk("lu_model1", int'(m_stall), 1);
    tick();
    #1 chk("lu_stall2", int'(stall), 1);
    tick();
    #1 chk("lu_stall3", int'(stall), 0);
    chk("lu_fwd", int'(fwd_rs_d), 0);
    tick();

    // ALU-ALU
    drv(1, 0, 3, 0, 3, 1, 5, 1, 0, 0, 0);
    tick();
    drv(1, 5, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    #1 chk("alu_stall", int'(stall), 0);
    tick();
    drv(1, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("alu_fwd_rt", int'(fwd_rt_d), 1);
    model_eval();
    chk("alu_model", m_fwd_rt, 1);
    tick();

    // register 0
    drv(1, 0, 3, 0, 3, 1, 0, 2, 0, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("r0_stall", int'(stall), 0);
    tick();

    // youngest match, both ready
    drv(1, 0, 3, 0, 3, 1, 9, 0, 0, 0, 0);
    tick();
    tick();
    drv(1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    #1 chk("young_fwd", int'(fwd_rs_d), 2);
    model_eval();
    chk("young_model", m_fwd_rs, 2);
    tick();

    // youngest match not ready, older ready
    drv(1, 0, 3, 0, 3, 1, 11, 0, 0, 0, 0);
    tick();
    drv(1, 0, 3, 0, 3, 1, 11, 2, 0, 0, 0);
    tick();
    drv(1, 11, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    #1 chk("young_stall", int'(stall), 1);
    repeat (3) tick();

    // multiply then divide busy windows
    for (int p = 0; p < 2; p++) begin
      drv(1, 0, 3, 0, 3, 0, 0, 0, 1, p[0], 1);
      tick();
      drv(1, 0, 3, 0, 3, 1, 2, 1, 0, 0, 1);
      for (int i = 0; i < (p == 0 ? 5 : 10); i++) begin
        #1 chk("md_stall", int'(stall), 1);
        chk("md_busy_on", int'(md_busy), 1);
        tick();
      end
      #1 chk("md_free", int'(stall), 0);
      chk("md_busy_off", int'(md_busy), 0);
      tick();
    end

    // async reset mid-stall and mid-busy
    drv(1, 0, 3, 0, 3, 1, 8, 2, 1, 0, 1);
    tick();
    drv(1, 8, 0, 0, 3, 0, 0, 0, 0, 0, 1);
    #1 chk("ar_pre_stall", int'(stall), 1);
    chk("ar_pre_busy", int'(md_busy), 1);
    #1 reset = 1'b1;
    #1 chk("ar_stall", int'(stall), 0);
    chk("ar_busy", int'(md_busy), 0);
    chk("ar_fwd", int'(fwd_rs_d), 0);
    chk("ar_issue", int'(issue), 1);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("ar_post_stall", int'(stall), 0);
    tick();

    // bubble
    drv(1, 0, 3, 0, 3, 1, 7, 2, 0, 0, 0);
    tick();
    drv(0, 7, 0, 0, 3, 1, 12, 2, 0, 0, 0);
    #1 chk("bub_stall", int'(stall), 0);
    chk("bub_issue", int'(issue), 0);
    tick();
    drv(1, 12, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    #1 chk("bub_nomatch", int'(stall), 0);
    tick();

    // randomized traffic; stalled instructions are held in D
    for (int n = 0; n < 3000; n++) begin
      if (!(m_stall && ($urandom % 4 != 0))) begin
        bit ms;
        ms = ($urandom % 12 == 0);
        drv($urandom % 8 != 0,
            int'($urandom % 5), int'($urandom % 4),
            int'($urandom % 5), int'($urandom % 4),
            $urandom % 4 != 0,
            int'($urandom % 5), int'($urandom % 4),
            ms, $urandom % 2 == 0,
            ms || ($urandom % 6 == 0));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_hazard_scheduler.md
Name: grf_hazard_scheduler

Overview:
- Issue-side scheduler for the 5-stage MIPS pipeline.
- Tracks in-flight register-file writes in the E, M and W slots and tracks the multiply/divide unit busy window.
- From these it decides, each cycle, whether the D-stage instruction may issue or must stall.
- It also produces the D-stage operand forward selects.
- It sits beside the decoder. The register file's internal W-to-read bypass covers the W slot.

Parameters:
MULT_CYCLES, 5, busy cycles after a multiply start
DIV_CYCLES, 10, busy cycles after a divide start
CNT_W, 4, md counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
d_valid  in  1  D stage holds a real instruction
d_rs  in  5  source register 1 index
d_rt  in  5  source register 2 index
d_tuse_rs  in  2  cycles until rs is consumed; 3 = not used
d_tuse_rt  in  2  cycles until rt is consumed; 3 = not used
d_regwrite  in  1  instruction writes the register file
d_a3  in  5  destination register
d_tnew  in  2  cycles after E entry until the result can be forwarded (ALU=1, load=2)
d_md_start  in  1  instruction starts mult/div
d_md_div  in  1  with d_md_start: 1 = divide, 0 = multiply
d_md_use  in  1  instruction reads/writes HI/LO or starts the MDU
stall  out  1  freeze PC and D; a bubble enters E
issue  out  1  d_valid & ~stall
fwd_rs_d  out  2  0 = register file (includes W bypass), 1 = from M, 2 = from E
fwd_rt_d  out  2  same encoding as fwd_rs_d, for rt
md_busy  out  1  MDU counter non-zero

Behaviour:
- Slot storage: three slots E, M, W, each holding {wr, a3[4:0], tnew[1:0]}. wr = 0 means no write.
- Slot update on every clk edge, unconditionally:
  - W <= M, with tnew forced to 0.
  - M <= E, with tnew = sat_dec(E.tnew).
  - E <= issue ? {d_regwrite & (d_a3 != 0), d_a3, d_tnew} : bubble (wr = 0).
- sat_dec(x) = (x == 0) ? 0 : x - 1. Values never wrap.
- Writes to register 0 never create a valid wr, so register 0 never stalls and never forwards.
- Source match, per source r in {rs, rt}: ignored when r == 0 or tuse == 3.
  - Otherwise, select the youngest slot with wr = 1 and a3 == r. Priority E > M > W.
- Stall condition, for the selected slot: stall when slot.tnew > tuse.
- Forward select:
  - Selected slot is E with tnew == 0 -> 2.
  - Selected slot is M with tnew == 0 -> 1.
  - Selected slot is W, or no match, or tnew > 0 with no stall -> 0. Later-stage forwarding covers the last case and is out of scope here.
  - Forward selects are 0 whenever stall = 1.
- MDU counter md_cnt[CNT_W-1:0]:
  - On an edge with issue & d_md_start, load DIV_CYCLES if d_md_div, else MULT_CYCLES.
  - Else, if md_cnt != 0, decrement.
  - md_busy = (md_cnt != 0).
  - A start issued in cycle t gives md_busy = 1 for exactly N cycles, t+1 .. t+N.
- MDU stall: stall also asserts when d_valid & d_md_use & md_busy.
- Combining rules:
  - stall = d_valid & (rs_stall | rt_stall | md_stall).
  - With d_valid = 0, stall = 0 and issue = 0.
- Outputs are combinational from slot state, md_cnt and D inputs. There is no output register, and the decision takes effect in the same cycle.
- Reset, asynchronous: all slots clear to wr = 0, a3 = 0, tnew = 0, and md_cnt = 0. Consequently:
  - stall = 0 and issue = d_valid.
  - fwd_rs_d = fwd_rt_d = 0 and md_busy = 0.
- Reset mid-operation: any pending stall or busy window is abandoned at once. No state survives.
- Same register pending in several slots: only the youngest slot is considered; older writes are ignored.
- Stalled instruction: its inputs are held by D. This block is stateless regarding D.

Decomposition:
- Shared package (e.g. mips_pkg) holds:
  - FWD_GRF = 0, FWD_M = 1, FWD_E = 2.
  - TUSE_NONE = 3.
  - Slot struct/field widths.
  - Default MULT_CYCLES / DIV_CYCLES.
- One sub-module, md_busy_counter: holds the load/decrement counter and produces md_busy. The slot pipeline and match logic stay in the top module.

Test Plan:
- Load-use: issue load with d_a3 = 8, d_tnew = 2. Next cycle, D presents rs = 8, tuse_rs = 0 -> stall = 1 for 2 cycles. Then stall = 0 and fwd_rs_d = 0 (W bypass), since the producer has moved to W.
- ALU-ALU: issue d_a3 = 5, tnew = 1. Next cycle rs = 5, tuse_rs = 1 -> no stall. Cycle after that (producer in M, tnew 0), rt = 5, tuse 0 -> fwd_rt_d = 1.
- Register 0 and youngest match:
  - Writes to register 0 give no stall even with tnew = 2.
  - Two in-flight writes to register 9 (E tnew 0, M tnew 0) -> fwd_rs_d = 2.
- MDU: issue mult (d_md_start = 1, d_md_div = 0). The next 5 cycles show md_busy = 1, and an mfhi (d_md_use = 1) in D stalls exactly those 5 cycles. Repeat with div -> 10 cycles.
- Async reset: assert reset mid-stall and mid-MDU-busy, between clock edges -> stall, md_busy and fwd immediately 0. After release, the first instruction issues with no stall.
- Bubble: with d_valid = 0 in a stall-worthy configuration -> stall = 0, issue = 0. The E slot receives a bubble, shown by no later match on that register.
